l2_mem_arbiter: RTL and testbench

//  Shares one slow-memory port between the I-side and D-side miss/write-back

---
 rtl/l2_mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_l2_mem_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : l2_mem_arbiter
//  Description : Shares one slow-memory line port between the I-side and
//                D-side miss/write-back ports of the L2 cache. One whole
//                line transaction is granted at a time, its command is
//                latched, and the completion pulse is routed to the owner.
//  Revision    : 1.0 - initial release
// ============================================================================
module l2_mem_arbiter #(
  parameter int ADDR_W    = 28,
  parameter int DATA_W    = 128,
  parameter int PRIO_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  // I-side requester
  input  logic              l2i_read,
  input  logic              l2i_write,
  input  logic [ADDR_W-1:0] l2i_addr,
  input  logic [DATA_W-1:0] l2i_wdata,
  output logic [DATA_W-1:0] l2i_rdata,
  output logic              l2i_ready,
  // D-side requester
  input  logic              l2d_read,
  input  logic              l2d_write,
  input  logic [ADDR_W-1:0] l2d_addr,
  input  logic [DATA_W-1:0] l2d_wdata,
  output logic [DATA_W-1:0] l2d_rdata,
  output logic              l2d_ready,
  // Memory port
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  // Debug
  output logic              grant_d,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t              state_q,     state_d;
  logic                mem_read_q,  mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                grant_d_q,   grant_d_d;
  // Round-robin history: 1 when the D side owned the last finished transaction
  logic                last_d_q,    last_d_d;

  logic                w_req_i;
  logic                w_req_d;
  logic                w_pick_d;
  logic                w_in_grant;

  // A side requests when either command bit is up; read+write together is
  // passed through untouched.
  assign w_req_i = l2i_read | l2i_write;
  assign w_req_d = l2d_read | l2d_write;

  generate
    if (PRIO_MODE == 1) begin : g_fixed_prio
      // D side wins whenever it asks
      assign w_pick_d = w_req_d;
    end else begin : g_round_robin
      // D wins if it is alone, or on a tie when I was served last
      assign w_pick_d = w_req_d & (~w_req_i | ~last_d_q);
    end
  endgenerate

  // Next-state and command-latch computation for the grant FSM
  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    grant_d_d   = grant_d_q;
    last_d_d    = last_d_q;

    case (state_q)
      ST_IDLE: begin
        if (w_req_i | w_req_d) begin
          state_d   = ST_GRANT;
          grant_d_d = w_pick_d;
          if (w_pick_d) begin
            mem_read_d  = l2d_read;
            mem_write_d = l2d_write;
            mem_addr_d  = l2d_addr;
            mem_wdata_d = l2d_wdata;
          end else begin
            mem_read_d  = l2i_read;
            mem_write_d = l2i_write;
            mem_addr_d  = l2i_addr;
            mem_wdata_d = l2i_wdata;
          end
        end
      end

      ST_GRANT: begin
        // Command stays frozen until memory completes the line
        if (mem_ready) begin
          state_d     = ST_RELEASE;
          last_d_d    = grant_d_q;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end

      ST_RELEASE: begin
        // One dead cycle so two memory commands never abut
        state_d = ST_IDLE;
      end

      default: begin
        state_d     = ST_IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  // State and latched command registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      grant_d_q   <= 1'b0;
      last_d_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      grant_d_q   <= grant_d_d;
      last_d_q    <= last_d_d;
    end
  end

  assign w_in_grant = (state_q == ST_GRANT);

  // Completion pulse goes only to the owner and only while a grant is live
  assign l2i_ready = mem_ready & w_in_grant & ~grant_d_q;
  assign l2d_ready = mem_ready & w_in_grant &  grant_d_q;

  // Read data is broadcast; the ready pulse qualifies it
  assign l2i_rdata = mem_rdata;
  assign l2d_rdata = mem_rdata;

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  assign grant_d   = grant_d_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_l2_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_l2_mem_arbiter
//  Description : Directed self-checking bench for l2_mem_arbiter. One
//                round-robin instance and one fixed-priority instance, each
//                with its own fixed-latency memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_mem_arbiter;

  localparam int ADDR_W  = 28;
  localparam int DATA_W  = 128;
  localparam int MEM_LAT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Round-robin instance signals
  logic              l2i_read = 0, l2i_write = 0, l2d_read = 0, l2d_write = 0;
  logic [ADDR_W-1:0] l2i_addr = '0, l2d_addr = '0;
  logic [DATA_W-1:0] l2i_wdata = '0, l2d_wdata = '0;
  logic [DATA_W-1:0] l2i_rdata, l2d_rdata, mem_wdata, mem_rdata;
  logic              l2i_ready, l2d_ready, mem_read, mem_write, mem_ready, grant_d, busy;
  logic [ADDR_W-1:0] mem_addr;

  // Fixed-priority instance signals
  logic              fi_read = 0, fd_read = 0;
  logic [ADDR_W-1:0] fi_addr = '0, fd_addr = '0;
  logic [DATA_W-1:0] fi_rdata, fd_rdata, f_mem_wdata, f_mem_rdata;
  logic              fi_ready, fd_ready, f_mem_read, f_mem_write, f_mem_ready, f_grant_d, f_busy;
  logic [ADDR_W-1:0] f_mem_addr;

  int n_checks = 0;
  int n_fail   = 0;

  l2_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PRIO_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .l2i_read(l2i_read), .l2i_write(l2i_write), .l2i_addr(l2i_addr),
    .l2i_wdata(l2i_wdata), .l2i_rdata(l2i_rdata), .l2i_ready(l2i_ready),
    .l2d_read(l2d_read), .l2d_write(l2d_write), .l2d_addr(l2d_addr),
    .l2d_wdata(l2d_wdata), .l2d_rdata(l2d_rdata), .l2d_ready(l2d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .grant_d(grant_d), .busy(busy)
  );

  l2_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PRIO_MODE(1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .l2i_read(fi_read), .l2i_write(1'b0), .l2i_addr(fi_addr),
    .l2i_wdata('0), .l2i_rdata(fi_rdata), .l2i_ready(fi_ready),
    .l2d_read(fd_read), .l2d_write(1'b0), .l2d_addr(fd_addr),
    .l2d_wdata('0), .l2d_rdata(fd_rdata), .l2d_ready(fd_ready),
    .mem_read(f_mem_read), .mem_write(f_mem_write), .mem_addr(f_mem_addr),
    .mem_wdata(f_mem_wdata), .mem_rdata(f_mem_rdata), .mem_ready(f_mem_ready),
    .grant_d(f_grant_d), .busy(f_busy)
  );

  // Memory content is a pure function of the line address
  function automatic logic [DATA_W-1:0] line_of(input logic [ADDR_W-1:0] a);
    return {4{4'hA, a}};
  endfunction

  assign mem_rdata   = line_of(mem_addr);
  assign f_mem_rdata = line_of(f_mem_addr);

  // Fixed-latency memory models, stepping on the falling edge
  int                rr_cnt = 0, f_cnt = 0;
  logic              rr_rdy = 1'b0, f_rdy = 1'b0, man_rdy = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;

  always @(negedge clk) begin
    if (rr_rdy) rr_rdy = 1'b0;
    else if (mem_read || mem_write) begin
      rr_cnt = rr_cnt + 1;
      if (rr_cnt >= MEM_LAT) begin
        rr_rdy = 1'b1;
        rr_cnt = 0;
        if (mem_write) begin
          wr_addr = mem_addr;
          wr_data = mem_wdata;
        end
      end
    end else rr_cnt = 0;
  end

  always @(negedge clk) begin
    if (f_rdy) f_rdy = 1'b0;
    else if (f_mem_read || f_mem_write) begin
      f_cnt = f_cnt + 1;
      if (f_cnt >= MEM_LAT) begin
        f_rdy = 1'b1;
        f_cnt = 0;
      end
    end else f_cnt = 0;
  end

  assign mem_ready   = rr_rdy | man_rdy;
  assign f_mem_ready = f_rdy;

  // Ready-pulse counters and illegal-command flag for the round-robin side
  int i_rdy_cnt = 0, d_rdy_cnt = 0;
  always begin
    @(negedge clk);
    #2;
    if (l2i_ready) i_rdy_cnt = i_rdy_cnt + 1;
    if (l2d_ready) d_rdy_cnt = d_rdy_cnt + 1;
    if ((l2i_read && l2i_write) || (l2d_read && l2d_write))
      $display("WARNING: illegal read+write request at %0t", $time);
  end

  // Stimulus and sampling point: 1 time unit after the falling edge
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rr_ready(input bit want_d, input int budget,
                               output int ticks, output bit seen);
    seen  = 1'b0;
    ticks = 0;
    while (!seen && ticks < budget) begin
      tick();
      ticks++;
      if (want_d ? l2d_ready : l2i_ready) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    tick();
    tick();
    n_checks++; if (mem_read !== 1'b0)  begin n_fail++; $display("FAIL reset_mem_read: got %0b want 0", mem_read); end
    n_checks++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL reset_mem_write: got %0b want 0", mem_write); end
    n_checks++; if (mem_addr !== '0)    begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    n_checks++; if (mem_wdata !== '0)   begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_checks++; if (grant_d !== 1'b0)   begin n_fail++; $display("FAIL reset_grant_d: got %0b want 0", grant_d); end
    n_checks++; if ({l2i_ready, l2d_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", {l2i_ready, l2d_ready}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    int t; bit seen; int i0, d0;
    i0 = i_rdy_cnt; d0 = d_rdy_cnt;
    l2i_addr = 28'h0000123;
    l2i_read = 1'b1;
    n_checks++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL rd_same_cycle: mem_read got %0b want 0", mem_read); end
    tick();
    n_checks++; if (mem_read !== 1'b1)  begin n_fail++; $display("FAIL rd_mem_read: got %0b want 1", mem_read); end
    n_checks++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL rd_mem_write: got %0b want 0", mem_write); end
    n_checks++; if (mem_addr !== 28'h0000123) begin n_fail++; $display("FAIL rd_mem_addr: got %h want 0000123", mem_addr); end
    n_checks++; if (grant_d !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL rd_grant_busy: got %0b%0b want 01", grant_d, busy); end
    wait_rr_ready(1'b0, 20, t, seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL rd_ready_timeout: got none want l2i_ready"); end
    n_checks++; if (t != MEM_LAT - 1) begin n_fail++; $display("FAIL rd_latency: got %0d want %0d", t, MEM_LAT - 1); end
    n_checks++; if (l2i_rdata !== line_of(28'h0000123)) begin n_fail++; $display("FAIL rd_rdata: got %h want %h", l2i_rdata, line_of(28'h0000123)); end
    n_checks++; if (l2d_ready !== 1'b0) begin n_fail++; $display("FAIL rd_other_ready: got %0b want 0", l2d_ready); end
    l2i_read = 1'b0;
    tick();
    n_checks++; if (mem_read !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL rd_release: got read=%0b busy=%0b want 0 1", mem_read, busy); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rd_idle: busy got %0b want 0", busy); end
    n_checks++; if (i_rdy_cnt - i0 != 1 || d_rdy_cnt - d0 != 0) begin n_fail++; $display("FAIL rd_pulse_count: got i=%0d d=%0d want 1 0", i_rdy_cnt - i0, d_rdy_cnt - d0); end
  endtask

  task automatic test_tie();
    int t; bit seen; int gap; int i0, d0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    i0 = i_rdy_cnt; d0 = d_rdy_cnt;
    l2d_addr = 28'h0000456; l2d_wdata = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210; l2d_write = 1'b1;
    l2i_addr = 28'h0000789; l2i_read = 1'b1;
    tick();
    n_checks++; if ({mem_write, mem_read} !== 2'b10) begin n_fail++; $display("FAIL tie_first_cmd: got w/r=%b want 10", {mem_write, mem_read}); end
    n_checks++; if (grant_d !== 1'b1 || mem_addr !== 28'h0000456) begin n_fail++; $display("FAIL tie_first_owner: got gd=%0b addr=%h want 1 0000456", grant_d, mem_addr); end
    wait_rr_ready(1'b1, 20, t, seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL tie_d_timeout: got none want l2d_ready"); end
    n_checks++; if (l2i_ready !== 1'b0) begin n_fail++; $display("FAIL tie_i_ready_early: got %0b want 0", l2i_ready); end
    n_checks++; if (wr_addr !== 28'h0000456 || wr_data !== 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210) begin n_fail++; $display("FAIL tie_write_data: got %h/%h want 0000456/0123456789abcdeffedcba9876543210", wr_addr, wr_data); end
    l2d_write = 1'b0;
    tick();
    n_checks++; if ({mem_write, mem_read} !== 2'b00) begin n_fail++; $display("FAIL tie_gap: got w/r=%b want 00", {mem_write, mem_read}); end
    gap = 1;
    while (gap < 10) begin
      tick();
      if (mem_read) break;
      gap++;
    end
    n_checks++; if (gap != 2) begin n_fail++; $display("FAIL tie_gap_len: got %0d want 2", gap); end
    n_checks++; if (grant_d !== 1'b0 || mem_addr !== 28'h0000789) begin n_fail++; $display("FAIL tie_second_owner: got gd=%0b addr=%h want 0 0000789", grant_d, mem_addr); end
    wait_rr_ready(1'b0, 20, t, seen);
    n_checks++; if (!seen || l2i_rdata !== line_of(28'h0000789)) begin n_fail++; $display("FAIL tie_i_read: got seen=%0b data=%h want 1 %h", seen, l2i_rdata, line_of(28'h0000789)); end
    l2i_read = 1'b0;
    tick();
    tick();
    n_checks++; if (i_rdy_cnt - i0 != 1 || d_rdy_cnt - d0 != 1) begin n_fail++; $display("FAIL tie_pulse_count: got i=%0d d=%0d want 1 1", i_rdy_cnt - i0, d_rdy_cnt - d0); end
  endtask

  task automatic test_round_robin();
    bit got [4];
    bit exp [4];
    int n; int t;
    exp[0] = 1'b1; exp[1] = 1'b0; exp[2] = 1'b1; exp[3] = 1'b0;
    n = 0; t = 0;
    l2i_addr = 28'h0000111; l2d_addr = 28'h0000222;
    l2i_read = 1'b1; l2d_read = 1'b1;
    while (n < 4 && t < 60) begin
      tick();
      t++;
      if (l2d_ready)      begin got[n] = 1'b1; n++; end
      else if (l2i_ready) begin got[n] = 1'b0; n++; end
    end
    l2i_read = 1'b0; l2d_read = 1'b0;
    n_checks++; if (n != 4) begin n_fail++; $display("FAIL rr_count: got %0d grants want 4", n); end
    for (int k = 0; k < n; k++) begin
      n_checks++; if (got[k] !== exp[k]) begin n_fail++; $display("FAIL rr_order[%0d]: got d=%0b want d=%0b", k, got[k], exp[k]); end
    end
    tick(); tick(); tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_drain: busy got %0b want 0", busy); end
  endtask

  task automatic test_fixed_prio();
    bit got [4];
    int n; int nd; int t;
    n = 0; nd = 0; t = 0;
    fi_addr = 28'h0000333; fd_addr = 28'h0000444;
    fi_read = 1'b1; fd_read = 1'b1;
    while (n < 4 && t < 60) begin
      tick();
      t++;
      if (fd_ready) begin
        got[n] = 1'b1; n++; nd++;
        if (nd == 3) fd_read = 1'b0;
      end else if (fi_ready) begin
        got[n] = 1'b0; n++;
        n_checks++; if (fi_rdata !== line_of(28'h0000333)) begin n_fail++; $display("FAIL fp_i_rdata: got %h want %h", fi_rdata, line_of(28'h0000333)); end
        fi_read = 1'b0;
      end
    end
    fi_read = 1'b0; fd_read = 1'b0;
    n_checks++; if (n != 4) begin n_fail++; $display("FAIL fp_count: got %0d grants want 4", n); end
    for (int k = 0; k < n; k++) begin
      n_checks++; if (got[k] !== (k < 3)) begin n_fail++; $display("FAIL fp_order[%0d]: got d=%0b want d=%0b", k, got[k], (k < 3)); end
    end
    tick(); tick(); tick();
    n_checks++; if (f_busy !== 1'b0) begin n_fail++; $display("FAIL fp_drain: busy got %0b want 0", f_busy); end
  endtask

  task automatic test_latch_hold();
    int t; bit seen;
    l2d_addr  = 28'hABCDEF0;
    l2d_wdata = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    l2d_write = 1'b1;
    tick();
    n_checks++; if (mem_write !== 1'b1 || mem_addr !== 28'hABCDEF0) begin n_fail++; $display("FAIL hold_cmd: got w=%0b addr=%h want 1 abcdef0", mem_write, mem_addr); end
    l2d_addr  = 28'h1111111;
    l2d_wdata = '1;
    tick();
    n_checks++; if (mem_addr !== 28'hABCDEF0) begin n_fail++; $display("FAIL hold_addr: got %h want abcdef0", mem_addr); end
    n_checks++; if (mem_wdata !== 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF) begin n_fail++; $display("FAIL hold_wdata: got %h want deadbeef x4", mem_wdata); end
    wait_rr_ready(1'b1, 20, t, seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL hold_timeout: got none want l2d_ready"); end
    n_checks++; if (wr_addr !== 28'hABCDEF0 || wr_data !== 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF) begin n_fail++; $display("FAIL hold_mem_saw: got %h/%h want abcdef0/deadbeef x4", wr_addr, wr_data); end
    l2d_write = 1'b0;
    tick(); tick();
  endtask

  task automatic test_async_reset();
    int t; bit seen;
    l2i_addr = 28'h0000ABC;
    l2i_read = 1'b1;
    tick();
    tick();
    n_checks++; if (mem_read !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL ar_pre: got read=%0b busy=%0b want 1 1", mem_read, busy); end
    rst_n = 1'b0;
    l2i_read = 1'b0;
    #1;
    n_checks++; if ({mem_read, mem_write} !== 2'b00) begin n_fail++; $display("FAIL ar_cmd_drop: got r/w=%b want 00", {mem_read, mem_write}); end
    n_checks++; if (busy !== 1'b0 || mem_addr !== '0) begin n_fail++; $display("FAIL ar_state: got busy=%0b addr=%h want 0 0", busy, mem_addr); end
    tick();
    rst_n = 1'b1;
    tick();
    l2i_addr = 28'h0000DEF;
    l2i_read = 1'b1;
    wait_rr_ready(1'b0, 20, t, seen);
    n_checks++; if (!seen || l2i_rdata !== line_of(28'h0000DEF)) begin n_fail++; $display("FAIL ar_after: got seen=%0b data=%h want 1 %h", seen, l2i_rdata, line_of(28'h0000DEF)); end
    l2i_read = 1'b0;
    tick(); tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ar_idle: busy got %0b want 0", busy); end
  endtask

  task automatic test_spurious_ready();
    int t; bit seen; int i0, d0;
    i0 = i_rdy_cnt; d0 = d_rdy_cnt;
    man_rdy = 1'b1;
    #1;
    n_checks++; if ({l2i_ready, l2d_ready} !== 2'b00) begin n_fail++; $display("FAIL sp_idle_ready: got %b want 00", {l2i_ready, l2d_ready}); end
    tick();
    n_checks++; if (busy !== 1'b0 || mem_read !== 1'b0) begin n_fail++; $display("FAIL sp_idle_state: got busy=%0b read=%0b want 0 0", busy, mem_read); end
    man_rdy = 1'b0;
    l2i_addr = 28'h0000555;
    l2i_read = 1'b1;
    wait_rr_ready(1'b0, 20, t, seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL sp_timeout: got none want l2i_ready"); end
    l2i_read = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b1 || mem_read !== 1'b0) begin n_fail++; $display("FAIL sp_release: got busy=%0b read=%0b want 1 0", busy, mem_read); end
    man_rdy = 1'b1;
    #1;
    n_checks++; if ({l2i_ready, l2d_ready} !== 2'b00) begin n_fail++; $display("FAIL sp_release_ready: got %b want 00", {l2i_ready, l2d_ready}); end
    tick();
    n_checks++; if (busy !== 1'b0 || mem_read !== 1'b0) begin n_fail++; $display("FAIL sp_after_release: got busy=%0b read=%0b want 0 0", busy, mem_read); end
    man_rdy = 1'b0;
    tick();
    n_checks++; if (i_rdy_cnt - i0 != 1 || d_rdy_cnt - d0 != 0) begin n_fail++; $display("FAIL sp_pulse_count: got i=%0d d=%0d want 1 0", i_rdy_cnt - i0, d_rdy_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_round_robin();
    test_fixed_prio();
    test_latch_hold();
    test_async_reset();
    test_spurious_ready();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case a DUT event never arrives
  initial begin
    #100000;
    $display("FAIL watchdog: time %0t reached, want finish earlier", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
